// File: rtl/mem_addr_arb_pkg.sv
// Shared types and helpers for the memory address arbiter.
// Supports up to MAX_CH requesting channels.
package mem_addr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MAX_CH = 32;

    // Converts a one-hot vector into its bit index; an all-zero vector maps to 0.
    function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] oh);
        onehot_to_idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) onehot_to_idx = unsigned'(i);
        end
    endfunction

endpackage

// File: rtl/mem_addr_arb_pick.sv
// Combinational winner select: finds the first unmasked requester at or after `start`,
// wrapping from NCH-1 to 0. Returns the winner as a one-hot vector and as an index.
module mem_addr_arb_pick
    import mem_addr_arb_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] mask,
    input  logic [IW-1:0]  start,
    output logic [NCH-1:0] win_oh,
    output logic [IW-1:0]  win_idx,
    output logic           any
);

    logic [NCH-1:0]   elig;
    logic [2*NCH-1:0] elig_dbl;
    logic [NCH-1:0]   rot;
    logic [NCH-1:0]   rot_oh;
    logic [2*NCH-1:0] oh_dbl;

    assign elig = req & ~mask;
    assign any  = |elig;

    // Rotate so that `start` sits at bit 0, keep the lowest set bit, then rotate back.
    assign elig_dbl = {elig, elig} >> start;
    assign rot      = elig_dbl[NCH-1:0];
    assign rot_oh   = rot & (~rot + NCH'(1));
    assign oh_dbl   = {rot_oh, rot_oh} << start;
    assign win_oh   = oh_dbl[2*NCH-1:NCH];

    assign win_idx = IW'(onehot_to_idx(MAX_CH'(win_oh)));

endmodule

// File: rtl/mem_addr_arb.sv
// N-channel arbiter for the memory address bus: registers the winner's address on A until mem_ack.
// Define MEM_ADDR_ARB_RR_EN for round-robin arbitration; the default is fixed priority (ch0 first).
module mem_addr_arb
    import mem_addr_arb_pkg::*;
#(
    parameter int AW      = 8,
    parameter int NCH     = 2,
    parameter int TMO_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*AW-1:0] addr_in,
    input  logic              mem_ack,
    output logic [AW-1:0]     A,
    output logic              a_valid,
    output logic [NCH-1:0]    grant,
    output logic              tmo_err
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(TMO_CYC + 1);

    state_t         state;
    logic [CW-1:0]  tmo_cnt;
    logic [IW-1:0]  start;
    logic [NCH-1:0] win_oh;
    logic [IW-1:0]  win_idx;
    logic           any;
    logic           load;
    logic [AW-1:0]  win_addr;

`ifdef MEM_ADDR_ARB_RR_EN
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] next_ptr;

    assign start    = rr_ptr;
    assign next_ptr = (win_idx == IW'(NCH - 1)) ? '0 : win_idx + IW'(1);
`else
    assign start = '0;
`endif

    // The current owner (grant is all-zero while idle) is masked so a completing channel
    // cannot immediately re-win.
    mem_addr_arb_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .req     (req),
        .mask    (grant),
        .start   (start),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any)
    );

    assign win_addr = addr_in[int'(win_idx)*AW +: AW];
    assign load     = any && ((state == IDLE) || mem_ack);

    // NOTE: every register, including the RR pointer, is cleared by the async reset so an
    // interrupted access leaves no stale owner behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            A       <= '0;
            a_valid <= 1'b0;
            grant   <= '0;
            tmo_err <= 1'b0;
            tmo_cnt <= '0;
`ifdef MEM_ADDR_ARB_RR_EN
            rr_ptr  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            tmo_err <= 1'b0;
            if (load) begin
                A       <= win_addr;
                grant   <= win_oh;
                a_valid <= 1'b1;
                tmo_cnt <= '0;
                state   <= BUSY;
`ifdef MEM_ADDR_ARB_RR_EN
                rr_ptr  <= next_ptr;
`endif
            end else if (state == BUSY) begin
                if (mem_ack || (tmo_cnt == CW'(TMO_CYC - 1))) begin
                    // An ack on the final allowed cycle is a normal completion.
                    a_valid <= 1'b0;
                    grant   <= '0;
                    state   <= IDLE;
                    tmo_err <= ~mem_ack;
                end else begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_addr_arb.sv
// Bench for mem_addr_arb (NCH=4, AW=8, TMO_CYC=4): reference model compared every cycle plus
// directed literal checks. Honours MEM_ADDR_ARB_RR_EN like the design does.
module tb_mem_addr_arb;

    localparam int AW  = 8;
    localparam int N   = 4;
    localparam int TMO = 4;
`ifdef MEM_ADDR_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr_in;
    logic            mem_ack;
    logic [AW-1:0]   A;
    logic            a_valid;
    logic [N-1:0]    grant;
    logic            tmo_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_addr_arb #(
        .AW      (AW),
        .NCH     (N),
        .TMO_CYC (TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .addr_in (addr_in),
        .mem_ack (mem_ack),
        .A       (A),
        .a_valid (a_valid),
        .grant   (grant),
        .tmo_err (tmo_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access owner, its address, a cycle count and a rotating start point.
    bit            m_busy  = 1'b0;
    int            m_owner = 0;
    logic [AW-1:0] m_A     = '0;
    int            m_cnt   = 0;
    int            m_ptr   = 0;
    bit            m_tmo   = 1'b0;
    int            m_w;

    function automatic int pick(input logic [N-1:0] r, input int excl, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_owner = 0; m_A = '0; m_cnt = 0; m_ptr = 0; m_tmo = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (!m_busy || mem_ack) begin
                m_w = pick(req, m_busy ? m_owner : -1, m_ptr);
                if (m_w >= 0) begin
                    m_A     = addr_in[m_w*AW +: AW];
                    m_owner = m_w;
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                    if (RR) m_ptr = (m_w + 1) % N;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (m_cnt == TMO - 1) begin
                m_tmo  = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cmp_A",     32'(A),       32'(m_A));
            check("cmp_valid", 32'(a_valid), 32'(m_busy));
            check("cmp_grant", 32'(grant),   m_busy ? (32'd1 << m_owner) : 32'd0);
            check("cmp_tmo",   32'(tmo_err), 32'(m_tmo));
        end
    end

    // NOTE: inputs change on the falling edge so DUT and model both see stable values at posedge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_addr(input int ch, input logic [AW-1:0] v);
        addr_in[ch*AW +: AW] = v;
    endtask

    int seq_rr[6] = '{0, 1, 2, 3, 0, 1};
    int seq_fx[6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        rst_n = 1'b0; req = '0; addr_in = '0; mem_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_A", 32'(A), 32'h0);
        check("rst_valid", 32'(a_valid), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_tmo", 32'(tmo_err), 32'h0);

        // Single request on ch1, acked on the third BUSY cycle.
        set_addr(1, 8'h40); req = 4'b0010;
        tick();
        check("single_A", 32'(A), 32'h40);
        check("single_grant", 32'(grant), 32'h2);
        check("single_valid", 32'(a_valid), 32'h1);
        tick(); tick();
        mem_ack = 1'b1;
        tick();
        check("single_done_valid", 32'(a_valid), 32'h0);
        check("single_done_grant", 32'(grant), 32'h0);
        check("single_hold_A", 32'(A), 32'h40);
        mem_ack = 1'b0; req = '0;

        // Priority and back-to-back handover.
        set_addr(0, 8'h10); set_addr(1, 8'h20); req = 4'b0011;
        tick();
        check("prio_A", 32'(A), 32'h10);
        check("prio_grant", 32'(grant), 32'h1);
        mem_ack = 1'b1;
        tick();
        check("b2b_A", 32'(A), 32'h20);
        check("b2b_grant", 32'(grant), 32'h2);
        check("b2b_valid", 32'(a_valid), 32'h1);
        req = 4'b0010;
        tick();
        check("b2b_end_valid", 32'(a_valid), 32'h0);
        req = '0;

        // Ack while idle is ignored.
        tick(); tick();
        check("idle_ack_valid", 32'(a_valid), 32'h0);
        check("idle_ack_A", 32'(A), 32'h20);
        check("idle_ack_tmo", 32'(tmo_err), 32'h0);

        // Address change during BUSY, then timeout after TMO BUSY cycles.
        mem_ack = 1'b0; set_addr(0, 8'h55); req = 4'b0001;
        tick();
        check("frz_A0", 32'(A), 32'h55);
        set_addr(0, 8'h66);
        tick();
        check("frz_A1", 32'(A), 32'h55);
        tick(); tick();
        check("pre_tmo", 32'(tmo_err), 32'h0);
        check("pre_tmo_valid", 32'(a_valid), 32'h1);
        tick();
        check("tmo_pulse", 32'(tmo_err), 32'h1);
        check("tmo_valid", 32'(a_valid), 32'h0);
        check("tmo_grant", 32'(grant), 32'h0);
        tick();
        check("tmo_clear", 32'(tmo_err), 32'h0);
        check("rearb_A", 32'(A), 32'h66);
        check("rearb_grant", 32'(grant), 32'h1);
        tick(); tick(); tick();
        mem_ack = 1'b1;
        tick();
        check("ack_on_tmo_cycle", 32'(tmo_err), 32'h0);
        check("ack_on_tmo_valid", 32'(a_valid), 32'h0);
        mem_ack = 1'b0; req = '0;

        // Asynchronous reset in the middle of an access.
        set_addr(0, 8'h3C); req = 4'b0001;
        tick();
        check("pre_rst_A", 32'(A), 32'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_A", 32'(A), 32'h0);
        check("async_rst_valid", 32'(a_valid), 32'h0);
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_tmo", 32'(tmo_err), 32'h0);
        tick();

        // All channels requesting, acked every cycle.
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) set_addr(c, 8'hA0 + 8'(c));
        req = 4'b1111; mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int e;
            e = RR ? seq_rr[i] : seq_fx[i];
            tick();
            check($sformatf("arb_grant_%0d", i), 32'(grant), 32'd1 << e);
            check($sformatf("arb_A_%0d", i), 32'(A), 32'hA0 + 32'(e));
        end
        req = '0;
        tick();
        check("arb_end_valid", 32'(a_valid), 32'h0);
        mem_ack = 1'b0;

        // Highest-index channel alone.
        req = 4'b1000;
        tick();
        check("top_ch_grant", 32'(grant), 32'h8);
        check("top_ch_A", 32'(A), 32'hA3);
        mem_ack = 1'b1;
        tick();
        check("top_ch_done", 32'(a_valid), 32'h0);
        req = '0; mem_ack = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
